// File: rtl/axi_line_master.sv
// Cache-line AXI burst master: one INCR read burst per refill, one INCR write burst per writeback.
// Optional macro AXI_M_RAW_ORDER_EN serialises a refill behind any pending writeback.
`timescale 1ns/1ps
module axi_line_master #(
  parameter int LINE_BEATS = 4,
  parameter int OFFS_W     = $clog2(LINE_BEATS) + 3
) (
  input  logic                       clk,
  input  logic                       rst,
  // refill side
  input  logic                       rd_req,
  input  logic [31:0]                rd_addr,
  output logic                       rd_busy,
  output logic                       rd_beat_valid,
  output logic [63:0]                rd_beat_data,
  output logic [3:0]                 rd_beat_idx,
  output logic                       rd_done,
  output logic                       rd_err,
  // writeback side
  input  logic                       wr_req,
  input  logic [31:0]                wr_addr,
  input  logic [64*LINE_BEATS-1:0]   wr_line,
  output logic                       wr_busy,
  output logic                       wr_done,
  output logic                       wr_err,
  // AXI read address / data
  output logic [31:0]                araddr,
  output logic                       arvalid,
  output logic [1:0]                 arburst,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  input  logic                       arready,
  input  logic [63:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rvalid,
  input  logic                       rlast,
  output logic                       rready,
  // AXI write address / data / response
  output logic [31:0]                awaddr,
  output logic                       awvalid,
  output logic [1:0]                 awburst,
  output logic [7:0]                 awlen,
  input  logic                       awready,
  output logic [63:0]                wdata,
  output logic                       wlast,
  output logic [7:0]                 wstrb,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready
);
  localparam int         IDX_W    = $clog2(LINE_BEATS);
  localparam logic [3:0] R_LAST   = 4'(LINE_BEATS - 1);
  localparam logic [IDX_W-1:0] W_LAST = IDX_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_e;

  r_state_e r_state_q;
  w_state_e w_state_q;

  logic [31:0] araddr_q, awaddr_q;
  logic        arvalid_q, rready_q, rd_busy_q;
  logic        rd_beat_valid_q, rd_done_q, rd_err_q;
  logic [63:0] rd_beat_data_q;
  logic [3:0]  rd_beat_idx_q, rcnt_q;
  logic        rerr_q;

  logic        awvalid_q, wvalid_q, bready_q, wr_busy_q, wr_done_q, wr_err_q;
  logic [IDX_W-1:0] wcnt_q;
  logic [LINE_BEATS-1:0][63:0] line_q;

  logic rd_accept, wr_accept;
  logic r_hs, r_last, r_mismatch, r_bad, w_last;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{rd_addr[OFFS_W-1:0], wr_addr[OFFS_W-1:0]};

  always_comb begin
    wr_accept = wr_req && (w_state_q == W_IDLE);
`ifdef AXI_M_RAW_ORDER_EN
    // Writeback wins a tie and blocks refills until its response is back.
    rd_accept = rd_req && (r_state_q == R_IDLE) && !wr_busy_q && !wr_accept;
`else
    rd_accept = rd_req && (r_state_q == R_IDLE);
`endif
    r_hs       = rvalid && rready_q;
    r_last     = rlast || (rcnt_q == R_LAST);
    r_mismatch = rlast != (rcnt_q == R_LAST);
    r_bad      = rerr_q || (rresp != 2'b00) || r_mismatch;
    w_last     = (wcnt_q == W_LAST);
  end

  // Read path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q       <= R_IDLE;
      araddr_q        <= '0;
      arvalid_q       <= 1'b0;
      rready_q        <= 1'b0;
      rd_busy_q       <= 1'b0;
      rd_beat_valid_q <= 1'b0;
      rd_beat_data_q  <= '0;
      rd_beat_idx_q   <= '0;
      rd_done_q       <= 1'b0;
      rd_err_q        <= 1'b0;
      rcnt_q          <= '0;
      rerr_q          <= 1'b0;
    end else begin
      rd_beat_valid_q <= 1'b0;
      rd_done_q       <= 1'b0;
      rd_err_q        <= 1'b0;
      case (r_state_q)
        R_IDLE: if (rd_accept) begin
          araddr_q  <= {rd_addr[31:OFFS_W], {OFFS_W{1'b0}}};
          rcnt_q    <= '0;
          rerr_q    <= 1'b0;
          arvalid_q <= 1'b1;
          rd_busy_q <= 1'b1;
          r_state_q <= R_AR;
        end
        R_AR: if (arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          r_state_q <= R_DATA;
        end
        R_DATA: if (r_hs) begin
          rd_beat_valid_q <= 1'b1;
          rd_beat_data_q  <= rdata;
          rd_beat_idx_q   <= rcnt_q;
          rcnt_q          <= rcnt_q + 4'd1;
          rerr_q          <= r_bad;
          // Either rlast or a full count closes the burst; disagreement is flagged.
          if (r_last) begin
            rready_q  <= 1'b0;
            rd_busy_q <= 1'b0;
            rd_done_q <= 1'b1;
            rd_err_q  <= r_bad;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Write path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wr_busy_q <= 1'b0;
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      wcnt_q    <= '0;
      line_q    <= '0;
    end else begin
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      case (w_state_q)
        W_IDLE: if (wr_accept) begin
          awaddr_q  <= {wr_addr[31:OFFS_W], {OFFS_W{1'b0}}};
          line_q    <= wr_line;
          wcnt_q    <= '0;
          awvalid_q <= 1'b1;
          wr_busy_q <= 1'b1;
          w_state_q <= W_AW;
        end
        W_AW: if (awready) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          w_state_q <= W_DATA;
        end
        W_DATA: if (wready) begin
          wcnt_q <= wcnt_q + IDX_W'(1);
          if (w_last) begin
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b1;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (bvalid) begin
          bready_q  <= 1'b0;
          wr_busy_q <= 1'b0;
          wr_done_q <= 1'b1;
          wr_err_q  <= (bresp != 2'b00);
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign arburst       = 2'b01;
  assign arsize        = 3'd3;
  assign arlen         = 8'(LINE_BEATS - 1);
  assign awburst       = 2'b01;
  assign awlen         = 8'(LINE_BEATS - 1);
  assign wstrb         = 8'hFF;

  assign araddr        = araddr_q;
  assign arvalid       = arvalid_q;
  assign rready        = rready_q;
  assign rd_busy       = rd_busy_q;
  assign rd_beat_valid = rd_beat_valid_q;
  assign rd_beat_data  = rd_beat_data_q;
  assign rd_beat_idx   = rd_beat_idx_q;
  assign rd_done       = rd_done_q;
  assign rd_err        = rd_err_q;

  assign awaddr        = awaddr_q;
  assign awvalid       = awvalid_q;
  assign wvalid        = wvalid_q;
  // Payload comes straight from the line buffer; wlast only qualifies a live beat.
  assign wdata         = line_q[wcnt_q];
  assign wlast         = wvalid_q && w_last;
  assign bready        = bready_q;
  assign wr_busy       = wr_busy_q;
  assign wr_done       = wr_done_q;
  assign wr_err        = wr_err_q;
endmodule

// File: tb/tb_axi_line_master.sv
// Bench for axi_line_master: table-driven refills, hand-written write/reset/concurrency sequences,
// beat scoreboards fed at stimulus time and drained by negedge monitors.
`timescale 1ns/1ps
module tb_axi_line_master;
  localparam int LB = 4;

  logic clk, rst;
  logic rd_req, rd_busy, rd_beat_valid, rd_done, rd_err;
  logic [31:0] rd_addr;
  logic [63:0] rd_beat_data;
  logic [3:0]  rd_beat_idx;
  logic wr_req, wr_busy, wr_done, wr_err;
  logic [31:0] wr_addr;
  logic [64*LB-1:0] wr_line;
  logic [31:0] araddr, awaddr;
  logic arvalid, arready, rvalid, rlast, rready, awvalid, awready;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic [7:0] arlen, awlen, wstrb;
  logic [2:0] arsize;
  logic [63:0] rdata, wdata;
  logic wlast, wvalid, wready, bvalid, bready;

  axi_line_master #(.LINE_BEATS(LB)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy),
    .rd_beat_valid(rd_beat_valid), .rd_beat_data(rd_beat_data), .rd_beat_idx(rd_beat_idx),
    .rd_done(rd_done), .rd_err(rd_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_line(wr_line),
    .wr_busy(wr_busy), .wr_done(wr_done), .wr_err(wr_err),
    .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arlen(arlen), .arsize(arsize),
    .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awburst(awburst), .awlen(awlen), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_araddr;
    int          ar_wait;
    int          nbeats;
    int          rlast_at;
    int          bad_beat;
    logic [1:0]  bad_resp;
    logic        exp_err;
  } rvec_t;

  typedef struct { logic [63:0] d; logic [3:0] idx; } rbeat_t;
  typedef struct { logic [63:0] d; logic last; } wbeat_t;

  rbeat_t rq[$];
  wbeat_t wq[$];
  rvec_t  rv[6];
  int n_cmp = 0, n_bad = 0, wr_done_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rd_beat_valid) begin
      if (rq.size() == 0) chk("rd_beat_unexpected", 64'(rd_beat_valid), 64'd0);
      else begin
        rbeat_t e;
        e = rq.pop_front();
        chk("rd_beat_data", rd_beat_data, e.d);
        chk("rd_beat_idx", 64'(rd_beat_idx), 64'(e.idx));
      end
    end
    if (wvalid && wready) begin
      if (wq.size() == 0) chk("w_beat_unexpected", 64'(wvalid), 64'd0);
      else begin
        wbeat_t e;
        e = wq.pop_front();
        chk("wdata", wdata, e.d);
        chk("wlast", 64'(wlast), 64'(e.last));
        chk("wstrb", 64'(wstrb), 64'hFF);
      end
    end
    if (wr_done) wr_done_cnt++;
  end

  task automatic rd_start(input logic [31:0] addr);
    rd_req = 1'b1; rd_addr = addr;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic rd_finish(input rvec_t v);
    logic [63:0] d;
    chk("rd_busy_set", 64'(rd_busy), 64'd1);
    for (int i = 0; i <= v.ar_wait; i++) begin
      chk("arvalid_hold", 64'(arvalid), 64'd1);
      chk("araddr", 64'(araddr), 64'(v.exp_araddr));
      chk("rready_pre_ar", 64'(rready), 64'd0);
      if (i == v.ar_wait) arready = 1'b1;
      tick();
    end
    arready = 1'b0;
    chk("arvalid_drop", 64'(arvalid), 64'd0);
    chk("rready_data", 64'(rready), 64'd1);
    for (int b = 0; b < v.nbeats; b++) begin
      d = {v.addr, 32'hA5A5_0000 | 32'(b)};
      rvalid = 1'b1; rdata = d;
      rresp  = (b == v.bad_beat) ? v.bad_resp : 2'b00;
      rlast  = (b == v.rlast_at);
      rq.push_back('{d, 4'(b)});
      tick();
      if (b < v.nbeats - 1) chk("rd_done_early", 64'(rd_done), 64'd0);
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    chk("rd_done", 64'(rd_done), 64'd1);
    chk("rd_err", 64'(rd_err), 64'(v.exp_err));
    chk("rd_busy_clear", 64'(rd_busy), 64'd0);
    chk("rready_clear", 64'(rready), 64'd0);
    tick();
    chk("rd_done_pulse", 64'(rd_done), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
  endtask

  task automatic wr_start(input logic [31:0] addr, input logic [64*LB-1:0] line);
    wr_req = 1'b1; wr_addr = addr; wr_line = line;
    for (int b = 0; b < LB; b++) wq.push_back('{line[b*64 +: 64], (b == LB - 1)});
    tick();
    wr_req = 1'b0;
    wr_line = '0;
  endtask

  task automatic wr_finish(input logic [31:0] exp_awaddr, input int aw_wait,
                           input bit toggle, input logic [1:0] br);
    int start_done;
    chk("wr_busy_set", 64'(wr_busy), 64'd1);
    chk("awlen", 64'(awlen), 64'd3);
    chk("awburst", 64'(awburst), 64'd1);
    for (int i = 0; i <= aw_wait; i++) begin
      chk("awvalid_hold", 64'(awvalid), 64'd1);
      chk("awaddr", 64'(awaddr), 64'(exp_awaddr));
      chk("wvalid_pre_aw", 64'(wvalid), 64'd0);
      if (i == aw_wait) awready = 1'b1;
      tick();
    end
    awready = 1'b0;
    chk("awvalid_drop", 64'(awvalid), 64'd0);
    for (int c = 0; c < 64 && wq.size() > 0; c++) begin
      wready = toggle ? c[0] : 1'b1;
      tick();
    end
    wready = 1'b0;
    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("wvalid_after_last", 64'(wvalid), 64'd0);
    chk("bready_set", 64'(bready), 64'd1);
    start_done = wr_done_cnt;
    bvalid = 1'b1; bresp = br;
    for (int c = 0; c < 32; c++) begin
      tick();
      if (wr_done) break;
    end
    bvalid = 1'b0; bresp = 2'b00;
    chk("wr_done", 64'(wr_done), 64'd1);
    chk("wr_err", 64'(wr_err), 64'(br != 2'b00));
    chk("wr_busy_clear", 64'(wr_busy), 64'd0);
    chk("bready_clear", 64'(bready), 64'd0);
    chk("wr_done_once_so_far", 64'(wr_done_cnt - start_done), 64'd0);
  endtask

  initial begin
    logic [64*LB-1:0] l0, l1, l2;
    rvec_t sv;
    int dc;

    rv[0] = '{32'h8000_0018, 32'h8000_0000, 0, 4,  3, -1, 2'b00, 1'b0};
    rv[1] = '{32'h1234_567F, 32'h1234_5660, 5, 4,  3,  0, 2'b10, 1'b1};
    rv[2] = '{32'h8000_0040, 32'h8000_0040, 0, 2,  1,  0, 2'b10, 1'b1};
    rv[3] = '{32'h0000_003F, 32'h0000_0020, 1, 2,  1, -1, 2'b00, 1'b1};
    rv[4] = '{32'hFFFF_FFE5, 32'hFFFF_FFE0, 0, 4, -1, -1, 2'b00, 1'b1};
    rv[5] = '{32'h0000_1008, 32'h0000_1000, 2, 4,  3,  3, 2'b01, 1'b1};
    l0 = {64'hD3D3_0003_3333_3333, 64'hD2D2_0002_2222_2222,
          64'hD1D1_0001_1111_1111, 64'hD0D0_0000_0000_0000};
    l1 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
          64'hAAAA_5555_AAAA_5555, 64'h5555_AAAA_5555_AAAA};
    l2 = {64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002,
          64'h1111_0000_0000_0001, 64'h0000_0000_0000_0000};

    rst = 1'b1;
    rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_line = '0;
    arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
    tick();
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_busy", 64'({rd_busy, wr_busy}), 64'd0);
    chk("rst_done", 64'({rd_done, wr_done, rd_beat_valid}), 64'd0);
    chk("rst_wlast", 64'(wlast), 64'd0);
    chk("const_arburst", 64'(arburst), 64'd1);
    chk("const_arsize", 64'(arsize), 64'd3);
    chk("const_arlen", 64'(arlen), 64'd3);
    chk("const_wstrb", 64'(wstrb), 64'hFF);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      rd_start(rv[i].addr);
      rd_finish(rv[i]);
    end

    // Writeback with wready toggling every other cycle, OKAY response.
    wr_start(32'h8000_1000, l0);
    wr_finish(32'h8000_1000, 0, 1'b1, 2'b00);
    tick();
    // Unaligned writeback, AW stall, SLVERR response.
    wr_start(32'h8000_1037, l1);
    wr_finish(32'h8000_1020, 2, 1'b0, 2'b10);
    tick();

    // Simultaneous refill and writeback.
    sv = '{32'h8000_2010, 32'h8000_2000, 0, 4, 3, -1, 2'b00, 1'b0};
    rd_req = 1'b1; rd_addr = sv.addr;
    wr_start(32'h8000_2000, l2);
`ifdef AXI_M_RAW_ORDER_EN
    chk("sim_arvalid_held_off", 64'(arvalid), 64'd0);
    chk("sim_awvalid", 64'(awvalid), 64'd1);
    wr_finish(32'h8000_2000, 0, 1'b0, 2'b00);
    chk("sim_arvalid_until_done", 64'(arvalid), 64'd0);
    tick();
    rd_req = 1'b0;
    chk("sim_arvalid_after_done", 64'(arvalid), 64'd1);
`else
    rd_req = 1'b0;
    chk("sim_arvalid", 64'(arvalid), 64'd1);
    chk("sim_awvalid", 64'(awvalid), 64'd1);
    wr_finish(32'h8000_2000, 0, 1'b0, 2'b00);
    chk("sim_arvalid_still", 64'(arvalid), 64'd1);
`endif
    rd_finish(sv);

    // Reset in the middle of a write burst (beat 2 presented).
    wr_start(32'h4000_0100, l1);
    awready = 1'b1; tick(); awready = 1'b0;
    wready = 1'b1; tick(); tick(); wready = 1'b0;
    chk("mid_wvalid_before_rst", 64'(wvalid), 64'd1);
    chk("mid_wdata_beat2", wdata, l1[2*64 +: 64]);
    #2 rst = 1'b1;
    #1;
    chk("arst_wvalid", 64'(wvalid), 64'd0);
    chk("arst_awvalid", 64'(awvalid), 64'd0);
    chk("arst_bready", 64'(bready), 64'd0);
    chk("arst_wr_busy", 64'(wr_busy), 64'd0);
    chk("arst_wlast", 64'(wlast), 64'd0);
    wq.delete();
    dc = wr_done_cnt;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("no_done_after_rst", 64'(wr_done_cnt - dc), 64'd0);
    wr_start(32'h4000_0100, l0);
    wr_finish(32'h4000_0100, 1, 1'b1, 2'b00);
    tick();
    chk("post_rst_done_count", 64'(wr_done_cnt - dc), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
